// File: rtl/ysyx_22050133_fetch_buffer_pkg.sv
// Shared constants and types for the ysyx_22050133 instruction-fetch front end.
// One queue entry pairs a 64-bit pc with its 32-bit instruction word.
package ysyx_22050133_fetch_buffer_pkg;

   localparam logic [63:0] RESET_PC_DEFAULT = 64'h8000_0000;
   localparam int          INST_LEN         = 32;
   localparam int          PC_LEN           = 64;
   localparam logic [63:0] INST_BYTES       = 64'd4;

   typedef struct packed {
      logic [PC_LEN-1:0]   pc;
      logic [INST_LEN-1:0] inst;
   } fetch_entry_t;

   localparam int ENTRY_W = $bits(fetch_entry_t);

   function automatic logic [63:0] align_pc(input logic [63:0] pc);
      return {pc[63:2], 2'b00};
   endfunction

endpackage

// File: rtl/ysyx_22050133_sync_fifo.sv
// Generic synchronous FIFO with async-reset pointers; head is read combinationally.
// Flush beats push/pop; pop of an empty FIFO and push into a full FIFO without pop are ignored.
module ysyx_22050133_sync_fifo #(
   parameter  int DEPTH = 4,
   parameter  int WIDTH = 96,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   output logic [WIDTH-1:0] head_dat,
   input  logic             flush,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty    = (count == '0);
   assign full     = (count == CW'(DEPTH));
   assign do_pop   = pop & ~empty;
   assign do_push  = push & (~full | do_pop);
   assign head_dat = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage needs no reset: a slot is only read after it has been written.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= push_dat;
   end

endmodule

// File: rtl/ysyx_22050133_fetch_buffer.sv
// Fetch front end: credit-limited in-order imem requests, {pc,inst} queue toward IDREG.
// Response-to-out_valid is one cycle; a redirect flushes the queue and drops in-flight words.
module ysyx_22050133_fetch_buffer
   import ysyx_22050133_fetch_buffer_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [63:0] RESET_PC = ysyx_22050133_fetch_buffer_pkg::RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [63:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_pc,
   output logic [31:0] out_inst
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [63:0]   fetch_pc;
   logic [63:0]   rsp_pc;
   logic [CW-1:0] inflight;
   logic [CW-1:0] discard;
   logic [CW-1:0] count;
   logic [CW:0]   credits_used;
   logic          full;
   logic          empty;
   logic          req_fire;
   logic          rsp_push;
   logic          pop;
   fetch_entry_t  push_entry;
   fetch_entry_t  head;
   fetch_entry_t  hold_q;

   // Queued plus outstanding words never exceed DEPTH, so a response always has a slot.
   assign credits_used   = {1'b0, count} + {1'b0, inflight};
   assign imem_req_valid = ~rst & ~redirect_valid & (credits_used < (CW+1)'(DEPTH));
   assign imem_req_addr  = fetch_pc;
   assign req_fire       = imem_req_valid & imem_req_ready;

   assign rsp_push   = imem_rsp_valid & ~redirect_valid & (discard == '0);
   assign push_entry = '{pc: rsp_pc, inst: imem_rsp_data};

   assign out_valid = ~empty & ~redirect_valid;
   assign pop       = out_valid & out_ready;
   assign out_pc    = empty ? hold_q.pc   : head.pc;
   assign out_inst  = empty ? hold_q.inst : head.inst;

   ysyx_22050133_sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (rsp_push),
      .push_dat (push_entry),
      .pop      (pop),
      .head_dat (head),
      .flush    (redirect_valid),
      .full     (full),
      .empty    (empty),
      .count    (count)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc <= RESET_PC;
         rsp_pc   <= RESET_PC;
         inflight <= '0;
         discard  <= '0;
      end else if (redirect_valid) begin
         // Every word still owed by memory belongs to the old stream, including one arriving now.
         fetch_pc <= align_pc(redirect_pc);
         rsp_pc   <= align_pc(redirect_pc);
         inflight <= inflight - CW'(imem_rsp_valid);
         discard  <= inflight - CW'(imem_rsp_valid);
      end else begin
         if (req_fire) fetch_pc <= fetch_pc + INST_BYTES;
         if (rsp_push) rsp_pc   <= rsp_pc + INST_BYTES;
         inflight <= inflight + CW'(req_fire) - CW'(imem_rsp_valid);
         if (imem_rsp_valid && (discard != '0)) discard <= discard - CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)         hold_q <= '0;
      else if (!empty) hold_q <= head;
   end

   no_overflow: assert property (@(posedge clk) disable iff (rst) !(rsp_push && full && !pop));

endmodule
